mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for the CPU's load/store port. Accepts one request at
//   a time (word/halfword/byte, read or write), inserts programmable wait states,
//   does read-modify-write for sub-word stores and returns a one-cycle response.
//   Flags misaligned, out-of-range and illegal-size accesses so the CPU control
//   unit can raise an exception (Cause/EPC path).
// PARAMETERS
//   MEM_WORDS    256  number of 32-bit words in internal storage (word index = addr[31:2])
//   WAIT_CYCLES  1    extra wait cycles per RAM access (0..15)
// PORTS
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-high
//   req_valid  in   1   request present; sampled only when req_ready=1
//   req_ready  out  1   responder idle and able to accept a request
//   req_we     in   1   1=store, 0=load
//   req_size   in   2   00=word, 01=halfword, 10=byte, 11=illegal
//   req_addr   in   32  byte address
//   req_wdata  in   32  store data; half/byte data taken from bits [15:0]/[7:0]
//   rsp_valid  out  1   one-cycle pulse: request complete
//   rsp_rdata  out  32  load data, zero-extended for half/byte; 0 for stores/errors
//   rsp_err    out  1   valid with rsp_valid: access rejected, memory unchanged
// BEHAVIOUR
//   - Reset: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, wait
//     counter=0. RAM contents are NOT cleared. A reset mid-operation aborts the
//     request. No RAM write occurs unless the WRITE cycle has completed.
//   - Request fields are latched on accept (req_valid & req_ready). Later input
//     changes are ignored. There is no response backpressure: the CPU must take
//     rsp_valid when it pulses.
//   - Lanes are little-endian. Byte k = word[8k+7:8k]. Half at addr[1]=h is word[16h+15:16h].
//   - Error check at accept: size=11; word with addr[1:0]!=0; half with
//     addr[0]!=0; or addr[31:2] >= MEM_WORDS. On error: IDLE->RESP, rsp_valid
//     and rsp_err assert in the next cycle, and the RAM is untouched.
//   - FSM: IDLE -> WAIT (count WAIT_CYCLES) -> ACCESS -> [MERGE -> WAIT2 -> WRITE]
//     -> RESP -> IDLE.
//     IDLE: req_ready=1. The only state that accepts requests.
//     WAIT/WAIT2: hold WAIT_CYCLES cycles. If WAIT_CYCLES=0, pass through in zero cycles.
//     ACCESS: a load or sub-word store reads the RAM word; a word store writes it.
//     MERGE: replace the addressed lane of the read word with the store data.
//     WRITE: write the merged word.
//     RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready=0 here, so
//     back-to-back requests are spaced by at least one idle cycle.
//   - Latency, counted from the accept edge T to the rsp_valid cycle:
//     load/word store = T+2+WAIT_CYCLES; sub-word store = T+4+2*WAIT_CYCLES;
//     error = T+1.
//   - rsp_rdata and rsp_err are registered. They are zeroed in every cycle where
//     rsp_valid=0.
//   - Wait counter width is 4 bits. The counter is reloaded on every WAIT entry.
// TESTING
//   1 Word store addr=0x10 data=0xDEADBEEF, then word load 0x10 -> rsp_rdata=0xDEADBEEF,
//     rsp_err=0, rsp_valid at T+3 with WAIT_CYCLES=1.
//   2 Over word 0x11223344 @0x20: sb 0xAA @0x21 then lw 0x20 -> 0x1122AA44.
//     sh 0x5566 @0x22 then lw -> 0x5566AA44. lbu @0x23 -> 0x00000055.
//   3 Misaligned lw @0x22, sh @0x21, size=11, addr=MEM_WORDS*4 -> each gives
//     rsp_err=1 at T+1 and a follow-up read shows memory unchanged.
//   4 Reset asserted in WAIT2 of an sb -> outputs at reset values immediately,
//     and the target word keeps its old value. The next request completes normally.
//   5 Hold req_valid=1 continuously with changing addresses -> requests are accepted
//     only in IDLE, one per transaction, and exactly one rsp_valid pulse per accept.
//   6 Sweep WAIT_CYCLES in {0,3} -> latencies match the formulas.
//     With 0, a load responds at T+2.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU load/store port: single outstanding request,
// programmable wait states, read-modify-write for sub-word stores, error flagging.
module mem_responder #(
   parameter int unsigned MEM_WORDS   = 256,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned IDXW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);
   localparam logic [3:0]  WAIT_LOAD  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_MERGE,
      S_WAIT2,
      S_WRITE,
      S_RESP
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic               r_we;
   logic [1:0]         r_size;
   logic [IDXW+1:0]    r_addr_lo;
   logic [31:0]        r_wdata;
   logic [31:0]        r_word;
   logic [3:0]         r_cnt;
   logic               r_rsp_valid;
   logic [31:0]        r_rsp_rdata;
   logic               r_rsp_err;
   logic [31:0]        r_mem [MEM_WORDS];

   logic               w_accept;
   logic               w_req_err;
   logic [IDXW-1:0]    w_idx;
   logic [31:0]        w_rd_word;
   logic [31:0]        w_load_data;
   logic [31:0]        w_merged;
   logic               w_mem_we;
   logic [31:0]        w_mem_wdata;
   logic               w_rsp_load;
   logic [31:0]        w_rsp_rdata;
   logic               w_rsp_err;
   logic               w_cnt_load;

   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

   assign w_accept  = req_valid & (r_state == S_IDLE);
   assign w_req_err = (req_size == 2'b11)
                    | ((req_size == 2'b00) & (req_addr[1:0] != 2'b00))
                    | ((req_size == 2'b01) & req_addr[0])
                    | (req_addr[31:2] >= WORD_LIMIT);
   assign w_idx     = r_addr_lo[IDXW+1:2];
   assign w_rd_word = r_mem[w_idx];

   // Little-endian lane extract (loads) and lane insert (sub-word stores).
   always_comb begin
      w_load_data = w_rd_word;
      w_merged    = r_word;
      case (r_size)
         2'b01: begin
            w_load_data = {16'h0000, w_rd_word[{r_addr_lo[1], 4'b0000} +: 16]};
            w_merged[{r_addr_lo[1], 4'b0000} +: 16] = r_wdata[15:0];
         end
         2'b10: begin
            w_load_data = {24'h000000, w_rd_word[{r_addr_lo[1:0], 3'b000} +: 8]};
            w_merged[{r_addr_lo[1:0], 3'b000} +: 8] = r_wdata[7:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_mem_we    = 1'b0;
      w_mem_wdata = r_wdata;
      w_rsp_load  = 1'b0;
      w_rsp_rdata = '0;
      w_rsp_err   = 1'b0;
      w_cnt_load  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_req_err) begin
                  w_next     = S_RESP;
                  w_rsp_load = 1'b1;
                  w_rsp_err  = 1'b1;
               end else if (WAIT_CYCLES == 0) begin
                  w_next = S_ACCESS;
               end else begin
                  w_next     = S_WAIT;
                  w_cnt_load = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) w_next = S_ACCESS;
         end
         S_ACCESS: begin
            if (r_we && (r_size != 2'b00)) begin
               w_next = S_MERGE;
            end else begin
               w_next     = S_RESP;
               w_rsp_load = 1'b1;
               if (r_we) w_mem_we    = 1'b1;
               else      w_rsp_rdata = w_load_data;
            end
         end
         S_MERGE: begin
            if (WAIT_CYCLES == 0) begin
               w_next = S_WRITE;
            end else begin
               w_next     = S_WAIT2;
               w_cnt_load = 1'b1;
            end
         end
         S_WAIT2: begin
            if (r_cnt == 4'd0) w_next = S_WRITE;
         end
         S_WRITE: begin
            w_mem_we    = 1'b1;
            w_mem_wdata = r_word;
            w_next      = S_RESP;
            w_rsp_load  = 1'b1;
         end
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_we        <= 1'b0;
         r_size      <= 2'b00;
         r_addr_lo   <= '0;
         r_wdata     <= '0;
         r_word      <= '0;
         r_cnt       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_we      <= req_we;
            r_size    <= req_size;
            r_addr_lo <= req_addr[IDXW+1:0];
            r_wdata   <= req_wdata;
         end
         if (r_state == S_ACCESS)     r_word <= w_rd_word;
         else if (r_state == S_MERGE) r_word <= w_merged;
         // Counter loads WAIT_CYCLES-1 on entry so the wait state lasts exactly WAIT_CYCLES.
         if (w_cnt_load)
            r_cnt <= WAIT_LOAD;
         else if ((r_state == S_WAIT || r_state == S_WAIT2) && r_cnt != 4'd0)
            r_cnt <= r_cnt - 4'd1;
         r_rsp_valid <= w_rsp_load;
         r_rsp_rdata <= w_rsp_load ? w_rsp_rdata : '0;
         r_rsp_err   <= w_rsp_load & w_rsp_err;
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[w_idx] <= w_mem_wdata;
   end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: instances with WAIT_CYCLES 0, 1 and 3,
// directed requests push expected responses, a negedge monitor pops and compares.
module tb_mem_responder;

   typedef struct {
      int          d;
      logic [31:0] rdata;
      logic        err;
      int          t;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        v0 = 1'b0, v1 = 1'b0, v3 = 1'b0;
   logic        rdy0, rdy1, rdy3;
   logic        rv0, rv1, rv3;
   logic [31:0] rd0, rd1, rd3;
   logic        er0, er1, er3;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   rsp_cnt1 = 0;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_responder #(.MEM_WORDS(256), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0), .req_we(req_we),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(er0));

   mem_responder #(.MEM_WORDS(256), .WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(er1));

   mem_responder #(.MEM_WORDS(256), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .reset(reset), .req_valid(v3), .req_ready(rdy3), .req_we(req_we),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(er3));

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   function automatic logic rdy(input int d);
      case (d)
         0:       return rdy0;
         3:       return rdy3;
         default: return rdy1;
      endcase
   endfunction

   task automatic set_v(input int d, input logic v);
      case (d)
         0:       v0 = v;
         3:       v3 = v;
         default: v1 = v;
      endcase
   endtask

   task automatic mon(input int d, input logic [31:0] rd, input logic er);
      exp_t e;
      if (q.size() == 0) begin
         chk("unexpected_rsp", 32'(d), 32'hFFFF_FFFF);
      end else begin
         e = q.pop_front();
         chk("rsp_dut", 32'(d), 32'(e.d));
         chk("rsp_rdata", rd, e.rdata);
         chk("rsp_err", {31'b0, er}, {31'b0, e.err});
         chk("rsp_latency", 32'(cyc + 1 - e.t), 32'(e.lat));
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (rv0) mon(0, rd0, er0);
         if (rv1) begin
            rsp_cnt1++;
            mon(1, rd1, er1);
         end
         if (rv3) mon(3, rd3, er3);
      end
   end

   task automatic issue(input int d, input logic we, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int lat);
      exp_t e;
      int   k;
      @(negedge clk);
      k = 0;
      while (!rdy(d) && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!rdy(d)) begin
         chk("ready_timeout", 32'(k), 32'd0);
         return;
      end
      req_we = we; req_size = sz; req_addr = addr; req_wdata = wdata;
      set_v(d, 1'b1);
      @(posedge clk);
      #1;
      e.d = d; e.rdata = exp_rd; e.err = exp_err; e.t = cyc; e.lat = lat;
      q.push_back(e);
      set_v(d, 1'b0);
      // Scramble inputs: the responder must hold the latched request.
      req_we = ~we; req_size = 2'b11; req_addr = 32'hFFFF_FFFF; req_wdata = ~wdata;
   endtask

   task automatic drain();
      int k = 0;
      while (q.size() != 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("drain_pending", 32'(q.size()), 32'd0);
   endtask

   initial begin
      logic [31:0] tbl [4];
      int          acc_cnt;
      int          rsp_base;
      logic        acc;
      exp_t        e;
      tbl[0] = 32'hA0A0_0001; tbl[1] = 32'hB1B1_0002;
      tbl[2] = 32'hC2C2_0003; tbl[3] = 32'hD3D3_0004;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", {31'b0, rdy1}, 32'd1);
      chk("reset_rsp_valid", {31'b0, rv1}, 32'd0);
      chk("reset_rdata", rd1, 32'd0);
      chk("reset_err", {31'b0, er1}, 32'd0);
      reset = 1'b0;

      // Word store then load, WAIT_CYCLES=1
      issue(1, 1, 2'b00, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 3);
      issue(1, 0, 2'b00, 32'h10, 32'h0,        32'hDEAD_BEEF, 0, 3);
      // Sub-word read-modify-write
      issue(1, 1, 2'b00, 32'h20, 32'h1122_3344, 32'h0, 0, 3);
      issue(1, 1, 2'b10, 32'h21, 32'hFFFF_FFAA, 32'h0, 0, 6);
      issue(1, 0, 2'b00, 32'h20, 32'h0, 32'h1122_AA44, 0, 3);
      issue(1, 1, 2'b01, 32'h22, 32'hFFFF_5566, 32'h0, 0, 6);
      issue(1, 0, 2'b00, 32'h20, 32'h0, 32'h5566_AA44, 0, 3);
      issue(1, 0, 2'b10, 32'h23, 32'h0, 32'h0000_0055, 0, 3);
      issue(1, 0, 2'b01, 32'h22, 32'h0, 32'h0000_5566, 0, 3);
      issue(1, 0, 2'b10, 32'h20, 32'h0, 32'h0000_0044, 0, 3);
      // Error cases leave memory intact
      issue(1, 1, 2'b00, 32'h0,   32'h0102_0304, 32'h0, 0, 3);
      issue(1, 1, 2'b00, 32'h3FC, 32'hCAFE_F00D, 32'h0, 0, 3);
      issue(1, 0, 2'b00, 32'h22,  32'h0,         32'h0, 1, 1);
      issue(1, 1, 2'b01, 32'h21,  32'hFFFF_FFFF, 32'h0, 1, 1);
      issue(1, 1, 2'b11, 32'h20,  32'hFFFF_FFFF, 32'h0, 1, 1);
      issue(1, 1, 2'b00, 32'h400, 32'hBAD0_BAD0, 32'h0, 1, 1);
      issue(1, 0, 2'b00, 32'h20,  32'h0, 32'h5566_AA44, 0, 3);
      issue(1, 0, 2'b00, 32'h0,   32'h0, 32'h0102_0304, 0, 3);
      issue(1, 0, 2'b00, 32'h3FC, 32'h0, 32'hCAFE_F00D, 0, 3);
      drain();

      // Reset during WAIT2 of a byte store aborts it
      issue(1, 1, 2'b10, 32'h10, 32'h0000_0077, 32'h0, 0, 6);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("abort_ready", {31'b0, rdy1}, 32'd1);
      chk("abort_rsp_valid", {31'b0, rv1}, 32'd0);
      chk("abort_rdata", rd1, 32'd0);
      q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      issue(1, 0, 2'b00, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 3);

      // Continuous req_valid with changing addresses
      for (int i = 0; i < 4; i++)
         issue(1, 1, 2'b00, 32'h40 + 32'(4 * i), tbl[i], 32'h0, 0, 3);
      drain();
      acc_cnt = 0;
      rsp_base = rsp_cnt1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         req_we = 1'b0; req_size = 2'b00; req_addr = 32'h40 + 32'(4 * (i % 4));
         v1 = 1'b1;
         acc = rdy1;
         @(posedge clk);
         #1;
         if (acc) begin
            e.d = 1; e.rdata = tbl[i % 4]; e.err = 1'b0; e.t = cyc; e.lat = 3;
            q.push_back(e);
            acc_cnt++;
         end
      end
      v1 = 1'b0;
      drain();
      chk("hold_accepts", 32'(acc_cnt), 32'd8);
      chk("hold_responses", 32'(rsp_cnt1 - rsp_base), 32'(acc_cnt));

      // WAIT_CYCLES = 0
      issue(0, 1, 2'b00, 32'h80, 32'h1357_9BDF, 32'h0, 0, 2);
      issue(0, 0, 2'b00, 32'h80, 32'h0, 32'h1357_9BDF, 0, 2);
      issue(0, 1, 2'b10, 32'h82, 32'h0000_00EE, 32'h0, 0, 4);
      issue(0, 0, 2'b00, 32'h80, 32'h0, 32'h13EE_9BDF, 0, 2);
      issue(0, 0, 2'b00, 32'h81, 32'h0, 32'h0, 1, 1);
      drain();
      // WAIT_CYCLES = 3
      issue(3, 1, 2'b00, 32'h84, 32'h2468_ACE0, 32'h0, 0, 5);
      issue(3, 0, 2'b00, 32'h84, 32'h0, 32'h2468_ACE0, 0, 5);
      issue(3, 1, 2'b01, 32'h84, 32'h0000_7788, 32'h0, 0, 10);
      issue(3, 0, 2'b00, 32'h84, 32'h0, 32'h2468_7788, 0, 5);
      issue(3, 0, 2'b11, 32'h84, 32'h0, 32'h0, 1, 1);
      drain();

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1);
   end

endmodule
